run_sequencer: RTL and testbench

- Upstream controller for the processor core: drives the core's `start` input, selects which of NUM_PROGS programs is loaded, and waits for `halt`.
- Runs programs 0..NUM_PROGS-1 back-to-back, measuring per-program execution cycles.
- Flags any program that fails to halt within TIMEOUT cycles.
- Sits between the bench/board-level `Go` and the core's `start` and `halt` pins.

---
 rtl/run_sequencer.sv | 168 ++++++++++++++++
 tb/tb_run_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - runs NUM_PROGS core programs back-to-back and logs per-program cycle counts
//
// Ports:
//   CLK         rising-edge clock
//   Init        asynchronous active-high reset
//   Go          level-sampled request to run the whole program sequence (ignored while Busy)
//   Halt        halt output of the processor core
//   Start       drives the core start pin, high INIT_CYCLES cycles before each program
//   ProgSel     program ROM bank select (index of the current program)
//   Busy        high in START, RUN and LOG (decoded from state)
//   Done        sequence finished; held until the next accepted Go
//   TimedOut    sticky: a program in this sequence hit TIMEOUT
//   CountValid  one-cycle pulse when CycleCount updates
//   CycleCount  run cycles of the most recently finished program
module run_sequencer #(
   parameter int NUM_PROGS   = 3,
   parameter int INIT_CYCLES = 2,
   parameter int TIMEOUT     = 1000,
   parameter int CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             Init,
   input  logic             Go,
   input  logic             Halt,
   output logic             Start,
   output logic [1:0]       ProgSel,
   output logic             Busy,
   output logic             Done,
   output logic             TimedOut,
   output logic             CountValid,
   output logic [CNT_W-1:0] CycleCount
);

   localparam int               INIT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  RUN_LIMIT = CNT_W'(TIMEOUT);
   localparam logic [1:0]        LAST_PROG = 2'(NUM_PROGS - 1);

   // Parameter sanity: the run counter must be able to hold TIMEOUT without wrapping.
   if (NUM_PROGS < 1 || NUM_PROGS > 4) begin : gBadNumProgs
      $error("run_sequencer: NUM_PROGS must be 1..4");
   end
   if (INIT_CYCLES < 1) begin : gBadInitCycles
      $error("run_sequencer: INIT_CYCLES must be >= 1");
   end
   if (TIMEOUT < 2) begin : gBadTimeoutLow
      $error("run_sequencer: TIMEOUT must be >= 2");
   end
   if (CNT_W < 31 && TIMEOUT >= (1 << CNT_W)) begin : gBadTimeoutHigh
      $error("run_sequencer: TIMEOUT must be below 2**CNT_W");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      RUN   = 3'd2,
      LOG   = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t             state, stateNext;
   logic [INIT_W-1:0]  initCnt, initCntNext;
   logic [CNT_W-1:0]   runCnt, runCntNext;
   logic               startNext;
   logic [1:0]         progSelNext;
   logic               doneNext;
   logic               timedOutNext;
   logic               countValidNext;
   logic [CNT_W-1:0]   cycleCountNext;

   always_ff @(posedge CLK or posedge Init) begin
      if (Init) begin
         state      <= IDLE;
         initCnt    <= '0;
         runCnt     <= '0;
         Start      <= 1'b0;
         ProgSel    <= 2'd0;
         Done       <= 1'b0;
         TimedOut   <= 1'b0;
         CountValid <= 1'b0;
         CycleCount <= '0;
      end else begin
         state      <= stateNext;
         initCnt    <= initCntNext;
         runCnt     <= runCntNext;
         Start      <= startNext;
         ProgSel    <= progSelNext;
         Done       <= doneNext;
         TimedOut   <= timedOutNext;
         CountValid <= countValidNext;
         CycleCount <= cycleCountNext;
      end
   end

   // The result is loaded on the RUN->LOG edge so CountValid and CycleCount are
   // visible during the LOG cycle, one cycle after Halt is sampled.
   always_comb begin
      stateNext      = state;
      initCntNext    = initCnt;
      runCntNext     = runCnt;
      startNext      = Start;
      progSelNext    = ProgSel;
      doneNext       = Done;
      timedOutNext   = TimedOut;
      countValidNext = 1'b0;
      cycleCountNext = CycleCount;

      case (state)
         IDLE, DONE: begin
            if (Go) begin
               stateNext    = START;
               startNext    = 1'b1;
               progSelNext  = 2'd0;
               timedOutNext = 1'b0;
               doneNext     = 1'b0;
               initCntNext  = '0;
            end
         end

         // Halt is deliberately not looked at here: it may still be stale from the previous program.
         START: begin
            if (initCnt == INIT_LAST) begin
               stateNext  = RUN;
               startNext  = 1'b0;
               runCntNext = '0;
            end else begin
               initCntNext = initCnt + INIT_W'(1);
            end
         end

         // A halt coinciding with the last allowed cycle wins over the timeout.
         RUN: begin
            if (Halt) begin
               stateNext      = LOG;
               countValidNext = 1'b1;
               cycleCountNext = runCnt;
            end else if (runCnt == RUN_LAST) begin
               stateNext      = LOG;
               countValidNext = 1'b1;
               cycleCountNext = RUN_LIMIT;
               timedOutNext   = 1'b1;
            end else begin
               runCntNext = runCnt + CNT_W'(1);
            end
         end

         LOG: begin
            if (ProgSel == LAST_PROG) begin
               stateNext = DONE;
               doneNext  = 1'b1;
            end else begin
               stateNext   = START;
               progSelNext = ProgSel + 2'd1;
               startNext   = 1'b1;
               initCntNext = '0;
            end
         end

         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   assign Busy = (state == START) || (state == RUN) || (state == LOG);

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - self-checking bench for run_sequencer
//
// Ports: none (top-level bench). Drives CLK, Init, Go, Halt; checks every run_sequencer output.
module tb_run_sequencer;

   localparam int NP = 3;
   localparam int IC = 2;
   localparam int TO = 20;
   localparam int CW = 16;

   logic          CLK = 1'b0;
   logic          Init;
   logic          Go;
   logic          Halt;
   logic          Start;
   logic [1:0]    ProgSel;
   logic          Busy;
   logic          Done;
   logic          TimedOut;
   logic          CountValid;
   logic [CW-1:0] CycleCount;

   always #5 CLK = ~CLK;

   run_sequencer #(
      .NUM_PROGS  (NP),
      .INIT_CYCLES(IC),
      .TIMEOUT    (TO),
      .CNT_W      (CW)
   ) dut (
      .CLK       (CLK),
      .Init      (Init),
      .Go        (Go),
      .Halt      (Halt),
      .Start     (Start),
      .ProgSel   (ProgSel),
      .Busy      (Busy),
      .Done      (Done),
      .TimedOut  (TimedOut),
      .CountValid(CountValid),
      .CycleCount(CycleCount)
   );

   typedef struct {
      logic          go;
      logic          halt;
      logic          start;
      logic [1:0]    progSel;
      logic          busy;
      logic          done;
      logic          timedOut;
      logic          countValid;
      logic [CW-1:0] cycleCount;
   } vec_t;

   vec_t vecs[$];

   int errors = 0;
   int checks = 0;

   // Reference model: architectural state visible at the outputs.
   logic [CW-1:0] mCount;
   logic          mTimed;
   logic          mDone;
   logic [1:0]    mSel;

   function automatic vec_t mkVec(input logic st, input logic bz, input logic cv);
      vec_t v;
      v.go         = 1'b0;
      v.halt       = 1'b0;
      v.start      = st;
      v.busy       = bz;
      v.countValid = cv;
      v.progSel    = mSel;
      v.done       = mDone;
      v.timedOut   = mTimed;
      v.cycleCount = mCount;
      return v;
   endfunction

   function automatic logic pickGo(input int mode);
      if (mode == 0) return 1'b0;
      if (mode == 1) return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic addIdle(input int n);
      for (int i = 0; i < n; i++) begin
         vec_t v;
         v = mkVec(1'b0, 1'b0, 1'b0);
         v.halt = 1'($urandom_range(0, 1));
         vecs.push_back(v);
      end
   endtask

   // d[p] = Halt=0 RUN cycles before the core halts; d[p] >= TO means it never halts.
   task automatic addSeq(input int d[NP], input int goMode, input int haltStartMode);
      vec_t v;
      v = vecs.pop_back();
      v.go = 1'b1;
      vecs.push_back(v);
      mSel   = 2'd0;
      mTimed = 1'b0;
      mDone  = 1'b0;
      for (int p = 0; p < NP; p++) begin
         int runLen;
         mSel = 2'(p);
         for (int i = 0; i < IC; i++) begin
            v = mkVec(1'b1, 1'b1, 1'b0);
            v.go   = pickGo(goMode);
            v.halt = (haltStartMode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
            vecs.push_back(v);
         end
         runLen = (d[p] < TO) ? d[p] + 1 : TO;
         for (int k = 0; k < runLen; k++) begin
            v = mkVec(1'b0, 1'b1, 1'b0);
            v.go   = pickGo(goMode);
            v.halt = (k == d[p]);
            vecs.push_back(v);
         end
         if (d[p] >= TO) begin
            mTimed = 1'b1;
            mCount = CW'(TO);
         end else begin
            mCount = CW'(d[p]);
         end
         v = mkVec(1'b0, 1'b1, 1'b1);
         v.go   = pickGo(goMode);
         v.halt = 1'($urandom_range(0, 1));
         vecs.push_back(v);
      end
      mDone = 1'b1;
      v = mkVec(1'b0, 1'b0, 1'b0);
      v.halt = 1'($urandom_range(0, 1));
      vecs.push_back(v);
   endtask

   // Entered and left at posedge+1; outputs are compared at the negedge of each cycle.
   task automatic applyVecs();
      for (int i = 0; i < vecs.size(); i++) begin
         Go   = vecs[i].go;
         Halt = vecs[i].halt;
         @(negedge CLK);
         checks++;
         if ({Start, ProgSel, Busy, Done, TimedOut, CountValid, CycleCount} !==
             {vecs[i].start, vecs[i].progSel, vecs[i].busy, vecs[i].done,
              vecs[i].timedOut, vecs[i].countValid, vecs[i].cycleCount}) begin
            errors++;
            $display("FAIL vec%0d: got start=%b sel=%0d busy=%b done=%b to=%b cv=%b cnt=%0d, want start=%b sel=%0d busy=%b done=%b to=%b cv=%b cnt=%0d",
                     i, Start, ProgSel, Busy, Done, TimedOut, CountValid, CycleCount,
                     vecs[i].start, vecs[i].progSel, vecs[i].busy, vecs[i].done,
                     vecs[i].timedOut, vecs[i].countValid, vecs[i].cycleCount);
         end
         @(posedge CLK);
         #1;
      end
      vecs.delete();
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic chkAllZero(input string name);
      chk({name, ".Start"},      32'(Start),      32'd0);
      chk({name, ".ProgSel"},    32'(ProgSel),    32'd0);
      chk({name, ".Busy"},       32'(Busy),       32'd0);
      chk({name, ".Done"},       32'(Done),       32'd0);
      chk({name, ".TimedOut"},   32'(TimedOut),   32'd0);
      chk({name, ".CountValid"}, 32'(CountValid), 32'd0);
      chk({name, ".CycleCount"}, 32'(CycleCount), 32'd0);
   endtask

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int dd[NP];
      Init   = 1'b1;
      Go     = 1'b0;
      Halt   = 1'b0;
      mCount = '0;
      mTimed = 1'b0;
      mDone  = 1'b0;
      mSel   = 2'd0;

      @(posedge CLK);
      #1;
      chkAllZero("reset");
      Init = 1'b0;

      // Directed sequences followed by randomized ones, all in one vector table.
      addIdle(2);
      dd = '{5, 7, 9};
      addSeq(dd, 0, 0);
      addIdle(3);
      dd = '{3, TO + 5, 4};
      addSeq(dd, 0, 0);
      addIdle(2);
      dd = '{0, 0, 0};
      addSeq(dd, 0, 1);
      addIdle(1);
      dd = '{TO - 1, 2, TO};
      addSeq(dd, 0, 0);
      addIdle(1);
      dd = '{1, 4, 2};
      addSeq(dd, 1, 0);
      dd = '{3, 0, TO - 1};
      addSeq(dd, 1, 0);
      dd = '{2, 2, 6};
      addSeq(dd, 1, 0);
      addIdle(2);
      for (int s = 0; s < 15; s++) begin
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 9) < 2) dd[p] = TO - 1 + int'($urandom_range(0, 2));
            else                         dd[p] = int'($urandom_range(0, 12));
         end
         addSeq(dd, 2, int'($urandom_range(0, 1)));
         addIdle(int'($urandom_range(0, 2)));
      end
      addIdle(1);
      applyVecs();

      // Init mid-RUN of program 1: launch, program 0 halts at once, then program 1 runs.
      Go   = 1'b1;
      Halt = 1'b1;
      @(posedge CLK);
      #1;
      Go = 1'b0;
      repeat (4) begin
         @(posedge CLK);
         #1;
      end
      Halt = 1'b0;
      repeat (4) begin
         @(posedge CLK);
         #1;
      end
      @(negedge CLK);
      chk("midrun.ProgSel",    32'(ProgSel),    32'd1);
      chk("midrun.Busy",       32'(Busy),       32'd1);
      chk("midrun.Start",      32'(Start),      32'd0);
      chk("midrun.CycleCount", 32'(CycleCount), 32'd0);
      #1;
      Init = 1'b1;
      #1;
      chkAllZero("async_init");
      @(posedge CLK);
      #1;
      Init = 1'b0;

      mCount = '0;
      mTimed = 1'b0;
      mDone  = 1'b0;
      mSel   = 2'd0;
      addIdle(1);
      dd = '{2, TO + 1, 1};
      addSeq(dd, 2, 0);
      addIdle(2);
      applyVecs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
